// File: rtl/decoder_sel_sequencer.sv
// Select/enable generator for a 3-to-8 decoder: steps sel either on a debounced
// button press (single-step) or from a free-running divider (auto-scan).
module decoder_sel_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SCAN_DIV        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_step,
    input  logic       run_en,
    input  logic       mode_auto,
    output logic [2:0] sel,
    output logic       en,
    output logic       step_pulse,
    output logic       wrap
);

    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DIV_W       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_ZERO = '0;
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Button synchroniser and debouncer
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   btn_s;

    logic [CNT_W-1:0] db_cnt_reg,     db_cnt_next;
    logic             db_level_reg,   db_level_next;
    logic             db_level_d_reg;
    logic             press_reg,      press_next;

    assign btn_s = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn_step};
        end
    end

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive
    // disagreeing samples; any agreeing sample restarts the run.
    always_comb begin
        db_cnt_next   = db_cnt_reg;
        db_level_next = db_level_reg;
        if (btn_s == db_level_reg) begin
            db_cnt_next = CNT_ZERO;
        end else if (db_cnt_reg == CNT_LAST) begin
            db_level_next = btn_s;
            db_cnt_next   = CNT_ZERO;
        end else begin
            db_cnt_next = db_cnt_reg + CNT_ONE;
        end
        press_next = db_level_reg & ~db_level_d_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_reg     <= CNT_ZERO;
            db_level_reg   <= 1'b0;
            db_level_d_reg <= 1'b0;
            press_reg      <= 1'b0;
        end else begin
            db_cnt_reg     <= db_cnt_next;
            db_level_reg   <= db_level_next;
            db_level_d_reg <= db_level_reg;
            press_reg      <= press_next;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_t           state_reg,      state_next;
    logic [DIV_W-1:0] div_reg,        div_next;
    logic [2:0]       sel_reg,        sel_next;
    logic             en_reg,         en_next;
    logic             step_pulse_reg, step_pulse_next;
    logic             wrap_reg,       wrap_next;
    logic             step;

    always_comb begin
        state_next = state_reg;
        div_next   = DIV_ZERO;
        step       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (run_en) begin
                    state_next = mode_auto ? ST_SCAN : ST_STEP;
                end
            end
            ST_STEP: begin
                step = press_reg;
                if (mode_auto) begin
                    state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                step = (div_reg == DIV_LAST);
                if (!mode_auto) begin
                    state_next = ST_STEP;
                end else if (div_reg != DIV_LAST) begin
                    div_next = div_reg + DIV_ONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Dropping run_en overrides everything, including a pending step.
        if (!run_en) begin
            state_next = ST_IDLE;
            div_next   = DIV_ZERO;
            step       = 1'b0;
        end

        sel_next        = step ? (sel_reg + 3'd1) : sel_reg;
        step_pulse_next = step;
        wrap_next       = step & (sel_reg == 3'd7);
        en_next         = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            div_reg        <= DIV_ZERO;
            sel_reg        <= 3'd0;
            en_reg         <= 1'b0;
            step_pulse_reg <= 1'b0;
            wrap_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            div_reg        <= div_next;
            sel_reg        <= sel_next;
            en_reg         <= en_next;
            step_pulse_reg <= step_pulse_next;
            wrap_reg       <= wrap_next;
        end
    end

    assign sel        = sel_reg;
    assign en         = en_reg;
    assign step_pulse = step_pulse_reg;
    assign wrap       = wrap_reg;

endmodule

// File: tb/tb_decoder_sel_sequencer.sv
// Randomised scoreboard bench for decoder_sel_sequencer: a behavioural model
// queues expected steps, a negedge monitor compares whatever the DUT presents.
module tb_decoder_sel_sequencer;

    localparam int DB = 16;
    localparam int SD = 8;
    localparam int M_IDLE = 0;
    localparam int M_STEP = 1;
    localparam int M_SCAN = 2;

    logic       clk;
    logic       rst_n;
    logic       btn_step;
    logic       run_en;
    logic       mode_auto;
    logic [2:0] sel;
    logic       en;
    logic       step_pulse;
    logic       wrap;

    int vectors     = 0;
    int miscompares = 0;

    decoder_sel_sequencer #(
        .DEBOUNCE_CYCLES(DB),
        .SCAN_DIV       (SD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_step  (btn_step),
        .run_en    (run_en),
        .mode_auto (mode_auto),
        .sel       (sel),
        .en        (en),
        .step_pulse(step_pulse),
        .wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    event rst_probe;

    // ------------------------------------------------------------------
    // Reference model: edges are numbered from reset release. The synced
    // button is the raw sample two edges old; a level is accepted once the
    // last DB synced samples all disagree with it and DB edges have passed
    // since the previous acceptance. A rising acceptance steps sel two edges
    // later if the sequencer is then in single-step mode.
    // ------------------------------------------------------------------
    int  edge_n    = 0;
    int  last_flip = 0;
    bit  m_lvl     = 0;
    bit  raw_q[$];
    bit  win_q[$];
    int  press_q[$];
    int  exp_q[$];
    int  m_mode    = M_IDLE;
    int  scan_age  = 0;
    int  m_sel     = 0;
    bit  m_en      = 0;

    always @(posedge clk) begin
        bit s;
        bit flip;
        bit press_now;
        bit do_step;
        int nxt;
        if (!rst_n) begin
            edge_n    = 0;
            last_flip = 0;
            m_lvl     = 0;
            raw_q.delete();
            win_q.delete();
            press_q.delete();
            exp_q.delete();
            m_mode    = M_IDLE;
            scan_age  = 0;
            m_sel     = 0;
            m_en      = 0;
        end else begin
            edge_n++;
            raw_q.push_back(btn_step);
            if (raw_q.size() > 3) void'(raw_q.pop_front());
            s = (raw_q.size() == 3) ? raw_q[0] : 1'b0;
            win_q.push_back(s);
            if (win_q.size() > DB) void'(win_q.pop_front());

            flip = (edge_n - last_flip >= DB) && (win_q.size() == DB);
            foreach (win_q[i]) if (win_q[i] == m_lvl) flip = 0;
            if (flip) begin
                if (!m_lvl) press_q.push_back(edge_n + 2);
                m_lvl     = !m_lvl;
                last_flip = edge_n;
            end

            press_now = 0;
            while (press_q.size() > 0 && press_q[0] <= edge_n) begin
                if (press_q[0] == edge_n) press_now = 1;
                void'(press_q.pop_front());
            end

            do_step = run_en && ((m_mode == M_STEP && press_now) ||
                                 (m_mode == M_SCAN && (scan_age % SD) == SD - 1));
            nxt = !run_en ? M_IDLE : (mode_auto ? M_SCAN : M_STEP);
            scan_age = (nxt == M_SCAN && m_mode == M_SCAN) ? scan_age + 1 : 0;
            if (do_step) begin
                m_sel = (m_sel + 1) % 8;
                exp_q.push_back(m_sel);
            end
            m_mode = nxt;
            m_en   = (nxt != M_IDLE);
        end
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk or rst_probe) begin
        int e;
        if (!rst_n) begin
            vectors++;
            if (sel !== 3'd0 || en !== 1'b0 || step_pulse !== 1'b0 || wrap !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_state: got sel=%0d en=%0b step=%0b wrap=%0b, required all 0",
                         sel, en, step_pulse, wrap);
            end
        end else begin
            vectors++;
            if (en !== m_en) begin
                miscompares++;
                $display("FAIL en @%0t: got %0b required %0b", $time, en, m_en);
            end
            vectors++;
            if (sel !== 3'(m_sel)) begin
                miscompares++;
                $display("FAIL sel @%0t: got %0d required %0d", $time, sel, m_sel);
            end
            if (step_pulse === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_step @%0t: got step_pulse=1 sel=%0d required no step",
                             $time, sel);
                end else begin
                    e = exp_q.pop_front();
                    if (sel !== 3'(e) || wrap !== (e == 0)) begin
                        miscompares++;
                        $display("FAIL step_value @%0t: got sel=%0d wrap=%0b required sel=%0d wrap=%0b",
                                 $time, sel, wrap, e, (e == 0));
                    end
                end
            end else begin
                vectors++;
                if (wrap !== 1'b0 || exp_q.size() != 0) begin
                    miscompares++;
                    $display("FAIL missing_step @%0t: got step_pulse=%0b wrap=%0b required step (queued=%0d)",
                             $time, step_pulse, wrap, exp_q.size());
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bounce(input int toggles, input int period);
        for (int i = 0; i < toggles; i++) begin
            btn_step = ~btn_step;
            wait_cycles(period);
        end
    endtask

    initial begin
        int  bounce_left;
        bit  target;

        rst_n     = 1'b0;
        btn_step  = 1'b0;
        run_en    = 1'b0;
        mode_auto = 1'b0;
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(3);

        // Auto-scan through a full wrap
        run_en    = 1'b1;
        mode_auto = 1'b1;
        wait_cycles(70);

        // Pause mid-scan and resume
        wait_cycles(13);
        run_en = 1'b0;
        wait_cycles(20);
        run_en = 1'b1;
        wait_cycles(30);

        // Single-step with a bouncy press, then release
        mode_auto = 1'b0;
        wait_cycles(4);
        bounce(13, 3);
        btn_step = 1'b1;
        wait_cycles(30);
        btn_step = 1'b0;
        wait_cycles(30);

        // Long hold, release, second press
        btn_step = 1'b1;
        wait_cycles(200);
        btn_step = 1'b0;
        wait_cycles(40);
        btn_step = 1'b1;
        wait_cycles(40);
        btn_step = 1'b0;
        wait_cycles(40);

        // Scan, drop to single-step with a press, then back to scan
        mode_auto = 1'b1;
        wait_cycles(12);
        mode_auto = 1'b0;
        btn_step  = 1'b1;
        wait_cycles(30);
        btn_step  = 1'b0;
        wait_cycles(30);
        mode_auto = 1'b1;
        wait_cycles(20);

        // Press arriving while idle must not be remembered
        run_en   = 1'b0;
        btn_step = 1'b1;
        wait_cycles(25);
        mode_auto = 1'b0;
        run_en    = 1'b1;
        wait_cycles(20);
        btn_step  = 1'b0;
        wait_cycles(25);

        // Randomised operation with bouncy button activity
        target      = 1'b0;
        bounce_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) == 0) run_en = ~run_en;
            if ($urandom_range(0, 79) == 0) mode_auto = ~mode_auto;
            if (bounce_left > 0) begin
                btn_step = 1'($urandom_range(0, 1));
                bounce_left--;
            end else begin
                btn_step = target;
                if ($urandom_range(0, 49) == 0) begin
                    target      = ~target;
                    bounce_left = $urandom_range(0, 10);
                end
            end
            wait_cycles(1);
        end

        // Reset in the middle of a scan
        btn_step  = 1'b0;
        run_en    = 1'b1;
        mode_auto = 1'b1;
        wait_cycles(50);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        -> rst_probe;
        run_en = 1'b0;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(5);
        run_en = 1'b1;
        wait_cycles(25);
        run_en = 1'b0;
        wait_cycles(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
